// File: rtl/otter_dmem_pkg.sv
// Shared types for the OTTER data-port arbiter: FSM states, access sizes, requester ids.
package otter_dmem_pkg;

    typedef enum logic {ARB_IDLE, ARB_RESP} arb_state_t;

    typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} mem_size_t;

    typedef enum logic {REQ_CPU = 1'b0, REQ_DBG = 1'b1} req_id_t;

    localparam logic [31:0] IO_BASE = 32'h1100_0000;

endpackage

// File: rtl/otter_rr_arb2.sv
// Two-way combinational arbiter: req[0]=CPU, req[1]=DBG, last=1 means DBG was granted last.
module otter_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       rr_en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = (rr_en && !last) ? 2'b10 : 2'b01;
        end else if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/otter_dmem_arbiter.sv
// Shares the OTTER memory data port between the MEM stage (CPU) and the debug loader (DBG).
// Optional grant/contention counters are enabled with `define OTTER_DMEM_ARB_STATS_EN.
//
//  state     | meaning
//  ARB_IDLE  | arbitrate, grant, issue write or read strobe
//  ARB_RESP  | read return cycle, address held, capture MEM_DOUT2
module otter_dmem_arbiter
    import otter_dmem_pkg::*;
#(
    parameter bit RR_EN  = 1'b1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [DATA_W-1:0] CPU_DIN,
    input  logic [1:0]        CPU_SIZE,
    input  logic              CPU_SIGN,
    output logic              CPU_GNT,
    output logic              CPU_RVALID,
    output logic [DATA_W-1:0] CPU_RDATA,
    input  logic              DBG_REQ,
    input  logic              DBG_WE,
    input  logic [ADDR_W-1:0] DBG_ADDR,
    input  logic [DATA_W-1:0] DBG_DIN,
    input  logic [1:0]        DBG_SIZE,
    input  logic              DBG_SIGN,
    output logic              DBG_GNT,
    output logic              DBG_RVALID,
    output logic [DATA_W-1:0] DBG_RDATA,
    output logic [ADDR_W-1:0] MEM_ADDR2,
    output logic [DATA_W-1:0] MEM_DIN2,
    output logic              MEM_WRITE2,
    output logic              MEM_READ2,
    output logic [1:0]        MEM_SIZE,
    output logic              MEM_SIGN,
    input  logic [DATA_W-1:0] MEM_DOUT2,
    output logic              BUSY
`ifdef OTTER_DMEM_ARB_STATS_EN
    ,
    input  logic              STAT_CLR,
    output logic [31:0]       STAT_CPU_GNTS,
    output logic [31:0]       STAT_DBG_GNTS,
    output logic [31:0]       STAT_CONTEND
`endif
);

    arb_state_t        state, state_nxt;
    req_id_t           last_gnt;  // doubles as owner of the read in flight
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [1:0]        arb_gnt, gnt;
    logic              win_dbg, win_we, last_dbg;

    assign last_dbg = (last_gnt == REQ_DBG);

    otter_rr_arb2 u_arb (
        .req   ({DBG_REQ, CPU_REQ}),
        .last  (last_dbg),
        .rr_en (RR_EN),
        .gnt   (arb_gnt)
    );

    always_comb begin
        gnt        = (state == ARB_IDLE && !RST) ? arb_gnt : 2'b00;
        win_dbg    = gnt[1];
        win_we     = win_dbg ? DBG_WE : CPU_WE;
        state_nxt  = state;
        MEM_ADDR2  = addr_q;
        MEM_SIZE   = size_q;
        MEM_SIGN   = sign_q;
        MEM_DIN2   = '0;
        MEM_WRITE2 = 1'b0;
        MEM_READ2  = 1'b0;
        if (gnt != 2'b00) begin
            MEM_ADDR2  = win_dbg ? DBG_ADDR : CPU_ADDR;
            MEM_SIZE   = win_dbg ? DBG_SIZE : CPU_SIZE;
            MEM_SIGN   = win_dbg ? DBG_SIGN : CPU_SIGN;
            MEM_DIN2   = win_dbg ? DBG_DIN  : CPU_DIN;
            MEM_WRITE2 = win_we;
            MEM_READ2  = !win_we;
            if (!win_we) state_nxt = ARB_RESP;
        end else if (state == ARB_RESP) begin
            state_nxt = ARB_IDLE;
        end
    end

    assign CPU_GNT = gnt[0];
    assign DBG_GNT = gnt[1];
    assign BUSY    = (state != ARB_IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ARB_IDLE;
            last_gnt   <= REQ_DBG;
            addr_q     <= '0;
            size_q     <= SZ_WORD;
            sign_q     <= 1'b0;
            CPU_RDATA  <= '0;
            DBG_RDATA  <= '0;
            CPU_RVALID <= 1'b0;
            DBG_RVALID <= 1'b0;
        end else begin
            state      <= state_nxt;
            CPU_RVALID <= (state == ARB_RESP) && (last_gnt == REQ_CPU);
            DBG_RVALID <= (state == ARB_RESP) && (last_gnt == REQ_DBG);
            if (state == ARB_RESP) begin
                if (last_gnt == REQ_CPU) CPU_RDATA <= MEM_DOUT2;
                else                     DBG_RDATA <= MEM_DOUT2;
            end
            if (gnt != 2'b00) begin
                last_gnt <= win_dbg ? REQ_DBG : REQ_CPU;
                addr_q   <= MEM_ADDR2;
                size_q   <= MEM_SIZE;
                sign_q   <= MEM_SIGN;
            end
        end
    end

`ifdef OTTER_DMEM_ARB_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            STAT_CPU_GNTS <= '0;
            STAT_DBG_GNTS <= '0;
            STAT_CONTEND  <= '0;
        end else if (STAT_CLR) begin
            STAT_CPU_GNTS <= '0;
            STAT_DBG_GNTS <= '0;
            STAT_CONTEND  <= '0;
        end else begin
            if (gnt[0] && STAT_CPU_GNTS != 32'hFFFF_FFFF) STAT_CPU_GNTS <= STAT_CPU_GNTS + 32'd1;
            if (gnt[1] && STAT_DBG_GNTS != 32'hFFFF_FFFF) STAT_DBG_GNTS <= STAT_DBG_GNTS + 32'd1;
            if (state == ARB_IDLE && CPU_REQ && DBG_REQ && STAT_CONTEND != 32'hFFFF_FFFF)
                STAT_CONTEND <= STAT_CONTEND + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_otter_dmem_arbiter.sv
// Bench for otter_dmem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_otter_dmem_arbiter;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic        cpu_req = 0, cpu_we = 0, cpu_sign = 0;
    logic [31:0] cpu_addr = 0, cpu_din = 0;
    logic [1:0]  cpu_size = 0;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dbg_req = 0, dbg_we = 0, dbg_sign = 0;
    logic [31:0] dbg_addr = 0, dbg_din = 0;
    logic [1:0]  dbg_size = 0;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic [31:0] mem_addr2, mem_din2, mem_dout2;
    logic        mem_write2, mem_read2, mem_sign, busy;
    logic [1:0]  mem_size;

    // second instance, fixed priority, with a constant memory return
    logic        f_cpu_req = 0, f_dbg_req = 0;
    logic        f_cpu_gnt, f_dbg_gnt, f_cpu_rvalid, f_dbg_rvalid;
    logic [31:0] f_cpu_rdata, f_dbg_rdata, f_mem_addr2, f_mem_din2;
    logic        f_mem_write2, f_mem_read2, f_mem_sign, f_busy;
    logic [1:0]  f_mem_size;

`ifdef OTTER_DMEM_ARB_STATS_EN
    logic [31:0] s_c, s_d, s_x, fs_c, fs_d, fs_x;
`endif

    otter_dmem_arbiter #(.RR_EN(1'b1)) dut (
        .CLK(CLK), .RST(RST),
        .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr), .CPU_DIN(cpu_din),
        .CPU_SIZE(cpu_size), .CPU_SIGN(cpu_sign), .CPU_GNT(cpu_gnt),
        .CPU_RVALID(cpu_rvalid), .CPU_RDATA(cpu_rdata),
        .DBG_REQ(dbg_req), .DBG_WE(dbg_we), .DBG_ADDR(dbg_addr), .DBG_DIN(dbg_din),
        .DBG_SIZE(dbg_size), .DBG_SIGN(dbg_sign), .DBG_GNT(dbg_gnt),
        .DBG_RVALID(dbg_rvalid), .DBG_RDATA(dbg_rdata),
        .MEM_ADDR2(mem_addr2), .MEM_DIN2(mem_din2), .MEM_WRITE2(mem_write2),
        .MEM_READ2(mem_read2), .MEM_SIZE(mem_size), .MEM_SIGN(mem_sign),
        .MEM_DOUT2(mem_dout2), .BUSY(busy)
`ifdef OTTER_DMEM_ARB_STATS_EN
        , .STAT_CLR(1'b0), .STAT_CPU_GNTS(s_c), .STAT_DBG_GNTS(s_d), .STAT_CONTEND(s_x)
`endif
    );

    otter_dmem_arbiter #(.RR_EN(1'b0)) dut_fp (
        .CLK(CLK), .RST(RST),
        .CPU_REQ(f_cpu_req), .CPU_WE(1'b0), .CPU_ADDR(32'h40), .CPU_DIN(32'h0),
        .CPU_SIZE(2'd2), .CPU_SIGN(1'b0), .CPU_GNT(f_cpu_gnt),
        .CPU_RVALID(f_cpu_rvalid), .CPU_RDATA(f_cpu_rdata),
        .DBG_REQ(f_dbg_req), .DBG_WE(1'b1), .DBG_ADDR(32'h80), .DBG_DIN(32'h1),
        .DBG_SIZE(2'd2), .DBG_SIGN(1'b0), .DBG_GNT(f_dbg_gnt),
        .DBG_RVALID(f_dbg_rvalid), .DBG_RDATA(f_dbg_rdata),
        .MEM_ADDR2(f_mem_addr2), .MEM_DIN2(f_mem_din2), .MEM_WRITE2(f_mem_write2),
        .MEM_READ2(f_mem_read2), .MEM_SIZE(f_mem_size), .MEM_SIGN(f_mem_sign),
        .MEM_DOUT2(32'hCAFE_F00D), .BUSY(f_busy)
`ifdef OTTER_DMEM_ARB_STATS_EN
        , .STAT_CLR(1'b0), .STAT_CPU_GNTS(fs_c), .STAT_DBG_GNTS(fs_d), .STAT_CONTEND(fs_x)
`endif
    );

    // little-endian byte memory behind the main instance; DOUT2 is only meaningful after a read
    logic [7:0] ram [1024];
    logic [7:0] mdl [1024];
    logic       rd_q = 1'b0;
    logic [9:0] ma;
    assign ma = mem_addr2[9:0];

    function automatic logic [31:0] load_val(input logic [7:0] b0, b1, b2, b3,
                                             input logic [1:0] sz, input logic sg);
        case (sz)
            2'd0:    return {{24{!sg && b0[7]}}, b0};
            2'd1:    return {{16{!sg && b1[7]}}, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    always @(posedge CLK) begin
        rd_q <= mem_read2;
        if (mem_write2) begin
            ram[ma] <= mem_din2[7:0];
            if (mem_size != 2'd0) ram[ma + 10'd1] <= mem_din2[15:8];
            if (mem_size >= 2'd2) begin
                ram[ma + 10'd2] <= mem_din2[23:16];
                ram[ma + 10'd3] <= mem_din2[31:24];
            end
        end
    end

    always_comb begin
        mem_dout2 = 32'hBADB_AD00;
        if (rd_q)
            mem_dout2 = load_val(ram[ma], ram[ma + 10'd1], ram[ma + 10'd2], ram[ma + 10'd3],
                                 mem_size, mem_sign);
    end

    function automatic logic [31:0] mdl_load(input logic [31:0] addr, input logic [1:0] sz,
                                             input logic sg);
        logic [9:0] a;
        a = addr[9:0];
        return load_val(mdl[a], mdl[a + 10'd1], mdl[a + 10'd2], mdl[a + 10'd3], sz, sg);
    endfunction

    task automatic mdl_write(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] d);
        logic [9:0] a;
        a = addr[9:0];
        mdl[a] = d[7:0];
        if (sz != 2'd0) mdl[a + 10'd1] = d[15:8];
        if (sz >= 2'd2) begin
            mdl[a + 10'd2] = d[23:16];
            mdl[a + 10'd3] = d[31:24];
        end
    endtask

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic clr_reqs();
        cpu_req = 0;
        dbg_req = 0;
    endtask

    task automatic drive(input bit who, input logic we, input logic [31:0] addr,
                         input logic [1:0] sz, input logic sg, input logic [31:0] d);
        if (who) begin
            dbg_req = 1; dbg_we = we; dbg_addr = addr; dbg_size = sz; dbg_sign = sg; dbg_din = d;
        end else begin
            cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_size = sz; cpu_sign = sg; cpu_din = d;
        end
    endtask

    task automatic do_reset();
        clr_reqs();
        RST = 1;
        tick();
        tick();
        RST = 0;
    endtask

    task automatic wr_txn(input bit who, input logic [31:0] addr, input logic [1:0] sz,
                          input logic [31:0] d);
        tick();
        clr_reqs();
        drive(who, 1'b1, addr, sz, 1'b0, d);
        sample();
        chk("wr_gnt", who ? dbg_gnt : cpu_gnt, 1);
        chk("wr_strobe", mem_write2, 1);
        chk("wr_addr", mem_addr2, addr);
        mdl_write(addr, sz, d);
    endtask

    task automatic rd_txn(input bit who, input logic [31:0] addr, input logic [1:0] sz,
                          input logic sg, input logic [31:0] exp);
        tick();
        clr_reqs();
        drive(who, 1'b0, addr, sz, sg, 32'h0);
        sample();
        chk("rd_gnt_t0", who ? dbg_gnt : cpu_gnt, 1);
        chk("rd_strobe_t0", mem_read2, 1);
        chk("rd_addr_t0", mem_addr2, addr);
        chk("rd_busy_t0", busy, 0);
        tick();
        clr_reqs();
        sample();
        chk("rd_strobe_t1", mem_read2, 0);
        chk("rd_addr_t1", mem_addr2, addr);
        chk("rd_busy_t1", busy, 1);
        chk("rd_rvalid_t1", who ? dbg_rvalid : cpu_rvalid, 0);
        tick();
        sample();
        chk("rd_rvalid_t2", who ? dbg_rvalid : cpu_rvalid, 1);
        chk("rd_other_rvalid_t2", who ? cpu_rvalid : dbg_rvalid, 0);
        chk("rd_data", who ? dbg_rdata : cpu_rdata, exp);
    endtask

    // randomized phase: agents and reference model state
    bit          act [2];
    logic        we_r [2], sg_r [2];
    logic [31:0] ad_r [2], dn_r [2];
    logic [1:0]  sz_r [2];
    int          w, m_last, m_rv, m_own;
    bit          m_resp, e_wr, e_rd;
    logic [31:0] m_pend;
    logic [31:0] m_rd [2];

    initial begin
        // reset state, with both requests high: no grants, no strobes
        cpu_req = 1;
        dbg_req = 1;
        sample();
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_dbg_gnt", dbg_gnt, 0);
        chk("rst_write2", mem_write2, 0);
        chk("rst_read2", mem_read2, 0);
        chk("rst_rvalid", {cpu_rvalid, dbg_rvalid}, 0);
        chk("rst_rdata", cpu_rdata | dbg_rdata, 0);
        chk("rst_busy", busy, 0);
        do_reset();

        // preload, then word and sub-word loads
        wr_txn(0, 32'h100, 2'd2, 32'hDEAD_BEEF);
        wr_txn(1, 32'h200, 2'd2, 32'h8011_2233);
        rd_txn(0, 32'h100, 2'd2, 1'b0, 32'hDEAD_BEEF);
        rd_txn(0, 32'h203, 2'd0, 1'b0, 32'hFFFF_FF80);
        rd_txn(0, 32'h203, 2'd0, 1'b1, 32'h0000_0080);
        rd_txn(1, 32'h202, 2'd1, 1'b0, 32'hFFFF_8011);

        // simultaneous stores straight out of reset: CPU first, then DBG
        do_reset();
        tick();
        drive(0, 1'b1, 32'h300, 2'd2, 1'b0, 32'h1111_1111);
        drive(1, 1'b1, 32'h304, 2'd2, 1'b0, 32'h2222_2222);
        sample();
        chk("sw_t0_cpu_gnt", cpu_gnt, 1);
        chk("sw_t0_dbg_gnt", dbg_gnt, 0);
        chk("sw_t0_write2", mem_write2, 1);
        chk("sw_t0_din", mem_din2, 32'h1111_1111);
        mdl_write(32'h300, 2'd2, 32'h1111_1111);
        tick();
        cpu_req = 0;
        sample();
        chk("sw_t1_dbg_gnt", dbg_gnt, 1);
        chk("sw_t1_write2", mem_write2, 1);
        chk("sw_t1_addr", mem_addr2, 32'h304);
        chk("sw_t1_din", mem_din2, 32'h2222_2222);
        mdl_write(32'h304, 2'd2, 32'h2222_2222);
        rd_txn(0, 32'h300, 2'd2, 1'b0, 32'h1111_1111);
        rd_txn(1, 32'h304, 2'd2, 1'b0, 32'h2222_2222);

        // reset during the return cycle discards the read
        tick();
        clr_reqs();
        drive(0, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
        sample();
        chk("rr_gnt", cpu_gnt, 1);
        tick();
        clr_reqs();
        sample();
        #1;
        RST = 1;
        cpu_req = 1;
        dbg_req = 1;
        #1;
        chk("rr_cpu_gnt_in_rst", cpu_gnt, 0);
        chk("rr_dbg_gnt_in_rst", dbg_gnt, 0);
        chk("rr_strobes_in_rst", {mem_read2, mem_write2}, 0);
        chk("rr_busy_in_rst", busy, 0);
        tick();
        sample();
        chk("rr_no_rvalid_a", cpu_rvalid, 0);
        tick();
        RST = 0;
        clr_reqs();
        sample();
        chk("rr_no_rvalid_b", cpu_rvalid, 0);
        rd_txn(0, 32'h100, 2'd2, 1'b0, 32'hDEAD_BEEF);

        // DBG request arriving in the return cycle waits one cycle
        tick();
        clr_reqs();
        drive(0, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
        sample();
        chk("rw_cpu_gnt", cpu_gnt, 1);
        tick();
        clr_reqs();
        drive(1, 1'b1, 32'h400, 2'd2, 1'b0, 32'h55AA_55AA);
        sample();
        chk("rw_no_gnt_in_resp", dbg_gnt, 0);
        chk("rw_no_write_in_resp", mem_write2, 0);
        chk("rw_addr_held", mem_addr2, 32'h100);
        tick();
        sample();
        chk("rw_dbg_gnt", dbg_gnt, 1);
        chk("rw_write2", mem_write2, 1);
        chk("rw_cpu_rvalid", cpu_rvalid, 1);
        chk("rw_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        mdl_write(32'h400, 2'd2, 32'h55AA_55AA);
        tick();
        clr_reqs();
        sample();
        chk("rw_cpu_rdata_kept", cpu_rdata, 32'hDEAD_BEEF);
        chk("rw_rvalid_done", {cpu_rvalid, dbg_rvalid}, 0);

        // fixed priority: continuous CPU reads starve DBG
        tick();
        f_cpu_req = 1;
        f_dbg_req = 1;
        for (int i = 0; i <= 10; i++) begin
            sample();
            chk("fp_dbg_starved", f_dbg_gnt, 0);
            chk("fp_cpu_gnt", f_cpu_gnt, (i % 2) == 0);
            chk("fp_cpu_rvalid", f_cpu_rvalid, (i >= 2) && ((i % 2) == 0));
            if (i >= 2 && (i % 2) == 0) chk("fp_cpu_rdata", f_cpu_rdata, 32'hCAFE_F00D);
            tick();
        end
        f_cpu_req = 0;
        sample();
        chk("fp_dbg_wait_resp", f_dbg_gnt, 0);
        tick();
        sample();
        chk("fp_dbg_gnt", f_dbg_gnt, 1);
        chk("fp_dbg_write", f_mem_write2, 1);
        tick();
        f_dbg_req = 0;

        // randomized traffic on the round-robin instance
        do_reset();
        act = '{0, 0};
        m_last = 1;
        m_rv = -1;
        m_own = 0;
        m_resp = 0;
        m_pend = 0;
        m_rd = '{32'h0, 32'h0};
        repeat (800) begin
            tick();
            for (int a = 0; a < 2; a++) begin
                if (!act[a]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        act[a]  = 1;
                        we_r[a] = 1'($urandom_range(0, 1));
                        ad_r[a] = 32'($urandom_range(0, 1023));
                        sz_r[a] = 2'($urandom_range(0, 2));
                        sg_r[a] = 1'($urandom_range(0, 1));
                        dn_r[a] = $urandom;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    act[a] = 0;
                end
            end
            cpu_req = act[0]; cpu_we = we_r[0]; cpu_addr = ad_r[0];
            cpu_size = sz_r[0]; cpu_sign = sg_r[0]; cpu_din = dn_r[0];
            dbg_req = act[1]; dbg_we = we_r[1]; dbg_addr = ad_r[1];
            dbg_size = sz_r[1]; dbg_sign = sg_r[1]; dbg_din = dn_r[1];
            sample();
            w = -1;
            if (!m_resp) begin
                if (act[0] && act[1]) w = (m_last == 0) ? 1 : 0;
                else if (act[0])      w = 0;
                else if (act[1])      w = 1;
            end
            e_wr = 0;
            e_rd = 0;
            if (w >= 0) begin
                e_wr = we_r[w];
                e_rd = !we_r[w];
                chk("rnd_addr", mem_addr2, ad_r[w]);
                if (e_wr) chk("rnd_din", mem_din2, dn_r[w]);
            end
            chk("rnd_cpu_gnt", cpu_gnt, w == 0);
            chk("rnd_dbg_gnt", dbg_gnt, w == 1);
            chk("rnd_write2", mem_write2, e_wr);
            chk("rnd_read2", mem_read2, e_rd);
            chk("rnd_busy", busy, m_resp);
            chk("rnd_cpu_rvalid", cpu_rvalid, m_rv == 0);
            chk("rnd_dbg_rvalid", dbg_rvalid, m_rv == 1);
            if (m_rv >= 0) m_rd[m_rv] = m_pend;
            chk("rnd_cpu_rdata", cpu_rdata, m_rd[0]);
            chk("rnd_dbg_rdata", dbg_rdata, m_rd[1]);
            m_rv = m_resp ? m_own : -1;
            m_resp = e_rd;
            if (w >= 0) begin
                m_last = w;
                act[w] = 0;
                if (e_rd) begin
                    m_own  = w;
                    m_pend = mdl_load(ad_r[w], sz_r[w], sg_r[w]);
                end else begin
                    mdl_write(ad_r[w], sz_r[w], dn_r[w]);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
